kbd_port: RTL and testbench

- PS/2 keyboard receiver plus CPU I/O-port read responder.
- Deserialises keyboard scan codes from the PS2_CLK/PS2_DAT lines into an 8-deep FIFO.
- Answers CPU port reads at 0060h (data) and 0064h (status).
- Sits beside the 03D4/03D5 write decoder in the top level. Driven by the 25 MHz CPU clock; its read data is muxed onto the CPU port input bus.

---
 rtl/kbd_port_if.sv | 16 +
 rtl/kbd_port.sv | 184 ++++++++++++++++++
 tb/tb_kbd_port.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/kbd_port_if.sv
// CPU port bus between the I/O decoder and the keyboard port.
//   pa        : CPU port address
//   pr        : CPU port read strobe (level, may span several cycles)
//   port_data : read data for the addressed port
//   port_hit  : address matches 0060h or 0064h
//   irq       : keyboard interrupt request (IRQ1 source)
interface kbd_port_if;
    logic [15:0] pa;
    logic        pr;
    logic [7:0]  port_data;
    logic        port_hit;
    logic        irq;

    modport master (output pa, output pr, input port_data, input port_hit, input irq);
    modport slave  (input pa, input pr, output port_data, output port_hit, output irq);
endinterface

// File: rtl/kbd_port.sv
// PS/2 keyboard receiver with scan-code FIFO and CPU port responder
// (0060h data, 0064h status).
//   clock   : 25 MHz system clock, posedge
//   reset_n : synchronous active-low reset
//   ps2_clk : raw PS/2 clock line (asynchronous)
//   ps2_dat : raw PS/2 data line (asynchronous)
//   bus     : CPU port bus (pa, pr in; port_data, port_hit, irq out)
module kbd_port #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    kbd_port_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic             clk_s1_q, clk_s2_q, clk_s3_q, dat_s1_q, dat_s2_q;
    logic [1:0]       state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             perr_q, perr_d, ovr_q, ovr_d;
    logic [7:0]       last_q, last_d;
    logic             pr_q, irq_q, irq_d;
    logic [7:0]       mem_q [DEPTH];

    logic fall, dat, rd_pulse, hit_data, hit_stat, empty, full, pop;
    logic push_req, push_ok, perr_set, ovr_set, stat_clr;
    logic [7:0] port_data_c;
    logic       port_hit_c;

    assign fall     = clk_s3_q & ~clk_s2_q;
    assign dat      = dat_s2_q;
    assign rd_pulse = bus.pr & ~pr_q;
    assign hit_data = (bus.pa == 16'h0060);
    assign hit_stat = (bus.pa == 16'h0064);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop      = rd_pulse & hit_data & ~empty;
    assign stat_clr = rd_pulse & hit_stat;

    // Frame receiver with inactivity timeout
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        to_d     = '0;
        push_req = 1'b0;
        perr_set = 1'b0;
        if (state_q != S_IDLE && !fall) to_d = to_q + TO_W'(1);
        case (state_q)
            S_IDLE: begin
                if (fall && !dat) begin
                    state_d  = S_DATA;
                    bitcnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d  = {dat, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = dat;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    // A low stop bit is a framing error and is dropped silently
                    if (dat) begin
                        if (^{shift_q, par_q}) push_req = 1'b1;
                        else                   perr_set = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && !fall && to_q == TO_W'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            to_d    = '0;
        end
    end

    // FIFO bookkeeping; a same-cycle pop makes room for a push into a full FIFO
    always_comb begin
        push_ok  = push_req & (~full | pop);
        ovr_set  = push_req & full & ~pop;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
        last_d   = pop ? mem_q[rd_ptr_q] : last_q;
        // Setting a flag wins over a status-read clear in the same cycle
        perr_d   = (perr_q & ~stat_clr) | perr_set;
        ovr_d    = (ovr_q & ~stat_clr) | ovr_set;
        irq_d    = ~empty;
    end

    // Port read mux
    always_comb begin
        port_data_c = 8'hFF;
        port_hit_c  = 1'b0;
        if (!reset_n) begin
            port_data_c = 8'h00;
        end else if (hit_data) begin
            port_hit_c  = 1'b1;
            port_data_c = empty ? last_q : mem_q[rd_ptr_q];
        end else if (hit_stat) begin
            port_hit_c  = 1'b1;
            port_data_c = {perr_q, ovr_q, 3'b000, 1'b1, 1'b0, ~empty};
        end
    end

    assign bus.port_data = port_data_c;
    assign bus.port_hit  = port_hit_c;
    assign bus.irq       = irq_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_s3_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            to_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            perr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            last_q   <= '0;
            pr_q     <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            dat_s1_q <= ps2_dat;
            dat_s2_q <= dat_s1_q;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            to_q     <= to_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            perr_q   <= perr_d;
            ovr_q    <= ovr_d;
            last_q   <= last_d;
            pr_q     <= bus.pr;
            irq_q    <= irq_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clock) begin
        if (reset_n && push_ok) mem_q[wr_ptr_q] <= shift_q;
    end
endmodule

// File: tb/tb_kbd_port.sv
// Directed bench for kbd_port: reset, frame receive, parity/framing errors,
// overflow, timeout and same-cycle push/pop on a full FIFO.
`timescale 1ns/1ps
module tb_kbd_port;
    localparam int HALF = 8;

    logic clock = 1'b0;
    logic reset_n, ps2_clk, ps2_dat;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] rd;

    always #20 clock = ~clock;

    kbd_port_if bus();

    kbd_port dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .bus     (bus)
    );

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    task automatic send_head(input logic [7:0] d, input logic par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_head(d, par);
        ps2_bit(stop);
        tick(4);
    endtask

    task automatic peek(input logic [15:0] a, output logic [7:0] d);
        bus.pa = a;
        #1;
        d = bus.port_data;
    endtask

    task automatic read_port(input logic [15:0] a, input int cyc, output logic [7:0] d);
        peek(a, d);
        bus.pr = 1'b1;
        tick(cyc);
        bus.pr = 1'b0;
        tick(2);
    endtask

    initial begin
        reset_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        bus.pa  = 16'h0060;
        bus.pr  = 1'b0;
        tick(1);
        check8("rst_hit", {7'b0, bus.port_hit}, 8'h00);
        check8("rst_data", bus.port_data, 8'h00);
        check8("rst_irq", {7'b0, bus.irq}, 8'h00);
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Partial frame interrupted by a 3-cycle reset
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        check8("mid_rst_irq", {7'b0, bus.irq}, 8'h00);
        peek(16'h0064, rd);
        check8("mid_rst_stat", rd, 8'h04);
        check8("stat_hit", {7'b0, bus.port_hit}, 8'h01);
        peek(16'h0060, rd);
        check8("mid_rst_data", rd, 8'h00);
        peek(16'h1234, rd);
        check8("other_data", rd, 8'hFF);
        check8("other_hit", {7'b0, bus.port_hit}, 8'h00);

        // Frame 1Ch with exact push / irq latency
        send_head(8'h1C, 1'b0);
        ps2_dat = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(3);
        check8("irq_lat0", {7'b0, bus.irq}, 8'h00);
        peek(16'h0064, rd);
        check8("stat_1c", rd, 8'h05);
        tick(1);
        check8("irq_lat1", {7'b0, bus.irq}, 8'h01);
        tick(HALF);
        ps2_clk = 1'b1;
        tick(4);
        read_port(16'h0060, 3, rd);
        check8("data_1c", rd, 8'h1C);
        check8("irq_after_pop", {7'b0, bus.irq}, 8'h00);
        peek(16'h0064, rd);
        check8("stat_after_pop", rd, 8'h04);
        peek(16'h0060, rd);
        check8("last_popped", rd, 8'h1C);

        // Parity error, then framing error
        send_frame(8'hF0, 1'b0, 1'b1);
        check8("perr_irq", {7'b0, bus.irq}, 8'h00);
        read_port(16'h0064, 1, rd);
        check8("perr_stat", rd, 8'h84);
        read_port(16'h0064, 1, rd);
        check8("perr_clr", rd, 8'h04);
        send_frame(8'h33, odd_par(8'h33), 1'b0);
        peek(16'h0064, rd);
        check8("frame_err", rd, 8'h04);

        // Overflow with 9 bytes
        for (int i = 1; i <= 9; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1);
        read_port(16'h0064, 1, rd);
        check8("ovr_stat", rd, 8'h45);
        for (int i = 1; i <= 8; i++) begin
            read_port(16'h0060, 2, rd);
            check8("ovr_data", rd, 8'(i));
            if (i == 7) check8("irq_7", {7'b0, bus.irq}, 8'h01);
        end
        check8("irq_8", {7'b0, bus.irq}, 8'h00);
        read_port(16'h0060, 1, rd);
        check8("empty_read", rd, 8'h08);
        peek(16'h0064, rd);
        check8("empty_stat", rd, 8'h04);

        // Timeout on a partial frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        tick(50010);
        send_frame(8'h5A, 1'b1, 1'b1);
        read_port(16'h0064, 1, rd);
        check8("to_stat", rd, 8'h05);
        read_port(16'h0060, 1, rd);
        check8("to_data", rd, 8'h5A);
        peek(16'h0064, rd);
        check8("to_empty", rd, 8'h04);

        // Full FIFO, pop timed onto the STOP resolve of frame 77h
        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), odd_par(8'h11 + 8'(i)), 1'b1);
        peek(16'h0064, rd);
        check8("full_stat", rd, 8'h05);
        send_head(8'h77, 1'b1);
        ps2_dat = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        bus.pa  = 16'h0060;
        tick(2);
        bus.pr  = 1'b1;
        tick(2);
        bus.pr  = 1'b0;
        tick(HALF - 2);
        ps2_clk = 1'b1;
        tick(4);
        peek(16'h0064, rd);
        check8("sim_stat", rd, 8'h05);
        for (int i = 0; i < 8; i++) begin
            read_port(16'h0060, 1, rd);
            check8("sim_data", rd, (i == 7) ? 8'h77 : 8'h12 + 8'(i));
        end
        peek(16'h0064, rd);
        check8("sim_empty", rd, 8'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
